// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller. Accepts one aligned memory instruction
// at a time from the MEM stage, runs a single req/ack DRAM transaction with
// variable latency, and reports completion, load data, misalignment and bus
// timeouts. The upstream pipeline is stalled while a transaction is in flight.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255  // REQ cycles without ack before bus error; 0 = never
) (
  input  logic        cpu_clk,
  input  logic        cpu_rstn,
  input  logic        ex_valid,
  input  logic        ex_we,
  input  logic [1:0]  ex_size,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        stall,
  output logic        dram_req,
  output logic        dram_we,
  output logic [29:0] dram_addr,
  output logic [3:0]  dram_wstrb,
  output logic [31:0] dram_wdata,
  input  logic        dram_ack,
  input  logic [31:0] dram_rdata,
  output logic        mem_done,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic [1:0]  ld_size,
  output logic        misalign,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter is wide enough to reach TIMEOUT_CYC-1; it simply wraps when the
  // timeout is disabled.
  localparam int unsigned CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cyc_cnt;
  logic          we_q;
  logic [1:0]    size_q;
  logic [1:0]    off_q;
  logic          err_q;

  logic          aligned;
  logic          accept;
  logic          tmo_hit;
  logic [3:0]    wstrb_nxt;
  logic [31:0]   wdata_nxt;
  logic [31:0]   ld_aligned;

  // Alignment check and store lane generation for the instruction in MEM.
  // NOTE: every signal assigned in an always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    aligned   = 1'b0;
    wstrb_nxt = 4'b0000;
    wdata_nxt = ex_wdata;
    case (ex_size)
      2'b00: begin
        aligned   = 1'b1;
        wstrb_nxt = 4'b0001 << ex_addr[1:0];
        wdata_nxt = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        aligned   = ~ex_addr[0];
        wstrb_nxt = 4'b0011 << ex_addr[1:0];
        wdata_nxt = {2{ex_wdata[15:0]}};
      end
      2'b10: begin
        aligned   = (ex_addr[1:0] == 2'b00);
        wstrb_nxt = 4'b1111;
        wdata_nxt = ex_wdata;
      end
      default: aligned = 1'b0;
    endcase
    if (!ex_we) wstrb_nxt = 4'b0000;
  end

  // Right-align the addressed lane(s) of the read word, zero-extended.
  always_comb begin
    ld_aligned = dram_rdata;
    case (size_q)
      2'b00: begin
        case (off_q)
          2'd0:    ld_aligned = {24'b0, dram_rdata[7:0]};
          2'd1:    ld_aligned = {24'b0, dram_rdata[15:8]};
          2'd2:    ld_aligned = {24'b0, dram_rdata[23:16]};
          default: ld_aligned = {24'b0, dram_rdata[31:24]};
        endcase
      end
      2'b01:   ld_aligned = off_q[1] ? {16'b0, dram_rdata[31:16]} : {16'b0, dram_rdata[15:0]};
      default: ld_aligned = dram_rdata;
    endcase
  end

  // Timeout fires on the TIMEOUT_CYC-th REQ cycle; an ack in that same cycle wins.
  assign tmo_hit = (TIMEOUT_CYC != 0) && (cyc_cnt == TMO_LAST);

  // State register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next-state and handshake/status outputs. Gating with cpu_rstn keeps
  // stall and misalign low for the whole time reset is held.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    stall     = 1'b0;
    misalign  = 1'b0;
    mem_done  = 1'b0;
    ld_valid  = 1'b0;
    bus_err   = 1'b0;
    case (state)
      IDLE: begin
        if (ex_valid && cpu_rstn) begin
          if (aligned) begin
            accept    = 1'b1;
            stall     = 1'b1;
            state_nxt = REQ;
          end else begin
            misalign  = 1'b1;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (dram_ack || tmo_hit) state_nxt = DONE;
      end
      DONE: begin
        mem_done  = 1'b1;
        ld_valid  = ~we_q;
        bus_err   = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // DRAM port registers, latched instruction fields and the REQ cycle counter.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      dram_req   <= 1'b0;
      dram_we    <= 1'b0;
      dram_addr  <= '0;
      dram_wstrb <= '0;
      dram_wdata <= '0;
      we_q       <= 1'b0;
      size_q     <= '0;
      off_q      <= '0;
      err_q      <= 1'b0;
      cyc_cnt    <= '0;
    end else if (accept) begin
      dram_req   <= 1'b1;
      dram_we    <= ex_we;
      dram_addr  <= ex_addr[31:2];
      dram_wstrb <= wstrb_nxt;
      dram_wdata <= wdata_nxt;
      we_q       <= ex_we;
      size_q     <= ex_size;
      off_q      <= ex_addr[1:0];
      err_q      <= 1'b0;
      cyc_cnt    <= '0;
    end else if (state == REQ) begin
      cyc_cnt <= cyc_cnt + CW'(1);
      if (dram_ack) begin
        dram_req <= 1'b0;
        err_q    <= 1'b0;
      end else if (tmo_hit) begin
        dram_req <= 1'b0;
        err_q    <= 1'b1;
      end
    end
  end

  // Load result registers: hold until the next load completes.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      ld_data <= '0;
      ld_size <= '0;
    end else if (state == REQ && !we_q && (dram_ack || tmo_hit)) begin
      ld_data <= dram_ack ? ld_aligned : 32'h0;
      ld_size <= size_q;
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage load/store controller between the EX/MEM pipeline register and the DRAM port.
- Issues one DRAM transaction per accepted memory instruction over a req/ack handshake with variable latency.
- Generates byte strobes and replicated write data for stores. Right-aligns load data (zero-extended) for the downstream byte/half sign-extension stage.
- Stalls the pipeline while busy, and flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYC, 255: REQ-state cycles without ack before bus error. 0 disables the timeout.

Ports:
- cpu_clk  in  1  single clock; all state updates on rising edge.
- cpu_rstn  in  1  asynchronous active-low reset.
- ex_valid  in  1  memory instruction present in MEM stage.
- ex_we  in  1  1 = store, 0 = load.
- ex_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- ex_addr  in  32  byte address.
- ex_wdata  in  32  store data, right-aligned.
- stall  out  1  freeze upstream pipeline.
- dram_req  out  1  transaction request, registered.
- dram_we  out  1  write enable, registered.
- dram_addr  out  30  word address (ex_addr[31:2]), registered.
- dram_wstrb  out  4  byte strobes, registered.
- dram_wdata  out  32  lane-replicated store data, registered.
- dram_ack  in  1  transaction complete; rdata valid same cycle for loads.
- dram_rdata  in  32  read word.
- mem_done  out  1  one-cycle completion pulse (load or store).
- ld_valid  out  1  one-cycle pulse: ld_data valid (loads only).
- ld_data  out  32  right-aligned, zero-extended load data.
- ld_size  out  2  size of completed load, for extension select downstream.
- misalign  out  1  one-cycle misaligned-access flag.
- bus_err  out  1  one-cycle timeout flag.

Behaviour:
- FSM states: IDLE, REQ, DONE. Reset → IDLE.
- Reset values: all registered outputs and the timeout counter are 0.
- Reset is asynchronous. Asserting it mid-REQ drops dram_req immediately and abandons the transaction. No mem_done is produced.
- Alignment rules:
  - half requires addr[0]=0.
  - word requires addr[1:0]=00.
  - size 11 is always misaligned.
- IDLE, ex_valid and aligned:
  - Latch we/size/addr/wdata and go to REQ.
  - dram_req rises on the next edge.
  - stall is combinational: high in this acceptance cycle.
- IDLE, ex_valid and misaligned:
  - misalign=1 combinationally for that cycle.
  - No DRAM access, no stall, no mem_done. Stay in IDLE.
- IDLE, no ex_valid: idle, stall=0.
- REQ:
  - dram_req and all dram_* outputs are held stable; stall=1.
  - The cycle counter increments each cycle.
  - On dram_ack=1, capture data and go to DONE. dram_req falls on the same edge.
  - An ack is valid in the first cycle dram_req is high.
- REQ timeout (TIMEOUT_CYC>0): when the counter reaches TIMEOUT_CYC without ack, go to DONE with bus_err. ld_data is forced to 0 and dram_req drops.
- DONE:
  - stall=0 and mem_done=1 for one cycle.
  - For loads: ld_valid=1, and ld_size is the latched size.
  - bus_err=1 if the transaction timed out.
  - Next state is IDLE. ex_* inputs are ignored in DONE; the next instruction is sampled in IDLE.
- Acks while in IDLE or DONE are ignored.
- Strobe generation: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111. Loads drive strobes 0.
- Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Load alignment, little-endian: byte {24'b0, rdata[8*addr[1:0] +: 8]}; half {16'b0, rdata[16*addr[1] +: 16]}; word rdata.
- ld_data holds its value until the next load completes.
- Latency: an ack-latency of N cycles after dram_req rises gives N+2 stall cycles (N=0: ack in first REQ cycle → 2 stall cycles).

Test Plan:
- Load byte: addr 0x00000103, dram_rdata 0xA1B2C3D4, ack in first REQ cycle → dram_addr 0x40, 2 stall cycles, ld_valid pulse, ld_data 0x000000A1, ld_size 00.
- Store half: addr 0x00000102, wdata 0x1234BEEF, ack latency 3 → dram_wstrb 4'b1100, dram_wdata 0xBEEFBEEF, dram_we 1, 5 stall cycles, mem_done pulse, ld_valid 0.
- Misaligned word: addr 0x00000101, ex_size 10 → misalign 1 for one cycle, dram_req stays 0, stall 0. Repeat with ex_size 11 at addr 0 → misalign.
- Timeout: TIMEOUT_CYC=4, load, ack never asserted → dram_req high exactly 4 cycles, then bus_err + mem_done + ld_valid pulse with ld_data 0. A subsequent late ack is ignored.
- Reset mid-REQ: cpu_rstn low while dram_req=1 → dram_req, stall and all flags 0 immediately. After release, a load of addr 0x4 with rdata 0xCAFEF00D gives ld_data 0xCAFEF00D.
- Back-to-back: load half addr 0x2 (rdata 0x8001xxxx) then store byte addr 0x1 → ld_data 0x00008001. The store is accepted in the IDLE cycle after DONE with wstrb 4'b0010.
